// File: rtl/avg_pkg.sv
//==============================================================================
// Module      : avg_pkg
// Description : Shared types and defaults for the vector generator line path.
// Revision    : 1.0 - parameterised line FIFO support
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package avg_pkg;

    localparam int COORD_W_DEF = 11;
    localparam int COLOR_W_DEF = 3;
    localparam int DEPTH_DEF   = 8;

    // One line segment at the default widths; packing order is sx (MSBs) down to color (LSBs)
    typedef struct packed {
        logic [COORD_W_DEF-1:0] sx;
        logic [COORD_W_DEF-1:0] sy;
        logic [COORD_W_DEF-1:0] ex;
        logic [COORD_W_DEF-1:0] ey;
        logic [COLOR_W_DEF-1:0] color;
    } line_t;

    // Packed width of one segment for arbitrary coordinate/colour widths
    function automatic int line_width(input int coord_w, input int color_w);
        return 4 * coord_w + color_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_fifo_ram.sv
//==============================================================================
// Module      : line_fifo_ram
// Description : DEPTH x WIDTH register file, one synchronous write port and
//               one combinational read port. Contents are not reset.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module line_fifo_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 47
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;

    // Write one entry per cycle; no reset because empty slots are never read out
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/line_fifo.sv
//==============================================================================
// Module      : line_fifo
// Description : First-word-fall-through FIFO of line segments between the
//               vector generator core and the line rasteriser. Edge or level
//               write mode, almost-full, occupancy, flush, sticky overflow.
// Revision    : 1.0 - replaces the fixed 11-bit depth-8 line queue
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module line_fifo
    import avg_pkg::*;
#(
    parameter int COORD_W   = COORD_W_DEF,
    parameter int COLOR_W   = COLOR_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AFULL_LVL = DEPTH - 2,
    parameter bit EDGE_WR   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     flush,
    input  logic                     wr,
    input  logic [COORD_W-1:0]       in_sx,
    input  logic [COORD_W-1:0]       in_sy,
    input  logic [COORD_W-1:0]       in_ex,
    input  logic [COORD_W-1:0]       in_ey,
    input  logic [COLOR_W-1:0]       in_color,
    input  logic                     rd,
    output logic [COORD_W-1:0]       out_sx,
    output logic [COORD_W-1:0]       out_sy,
    output logic [COORD_W-1:0]       out_ex,
    output logic [COORD_W-1:0]       out_ey,
    output logic [COLOR_W-1:0]       out_color,
    output logic                     empty,
    output logic                     full,
    output logic                     afull,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = c_aw + 1;
    localparam int c_ew = line_width(COORD_W, COLOR_W);

    localparam logic [c_lw-1:0] c_lvl_full  = c_lw'(DEPTH);
    localparam logic [c_lw-1:0] c_lvl_afull = c_lw'(AFULL_LVL);
    localparam logic [c_lw-1:0] c_lvl_one   = c_lw'(1);
    localparam logic [c_aw-1:0] c_ptr_one   = c_aw'(1);

    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_lw-1:0] r_level;
    logic            r_overflow;

    logic            w_wr_eff;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_empty;
    logic            w_full;
    logic [c_ew-1:0] w_wdata;
    logic [c_ew-1:0] w_rdata;
    logic [c_ew-1:0] w_head;

    // Write qualification: edge mode pushes once per rising edge of wr
    generate
        if (EDGE_WR) begin : g_edge_wr
            logic r_wr_q;

            // Delayed copy of wr for edge detection; keeps running through flush
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    r_wr_q <= 1'b0;
                end else begin
                    r_wr_q <= wr;
                end
            end

            assign w_wr_eff = wr && !r_wr_q;
        end else begin : g_level_wr
            assign w_wr_eff = wr;
        end
    endgenerate

    // Level is kept separately from the pointers so full and empty never alias
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_lvl_full);
    assign w_pop   = rd && !w_empty;
    assign w_push  = w_wr_eff && (!w_full || w_pop);
    assign w_drop  = w_wr_eff && w_full && !w_pop;
    assign w_wdata = {in_sx, in_sy, in_ex, in_ey, in_color};

    // Pointer and occupancy tracking; flush wins over push and pop
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_lvl_one;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_lvl_one;
            end
        end
    end

    // Sticky record of a dropped write; only reset or flush clears it
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    line_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (c_ew)
    ) u_ram (
        .clk   (clk),
        .we    (w_push && !flush),
        .waddr (r_wr_ptr),
        .wdata (w_wdata),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    // Head entry falls through; forced to zero so stale slots never leak out
    assign w_head = w_empty ? '0 : w_rdata;
    assign {out_sx, out_sy, out_ex, out_ey, out_color} = w_head;

    assign empty    = w_empty;
    assign full     = w_full;
    assign afull    = (r_level >= c_lvl_afull);
    assign level    = r_level;
    assign overflow = r_overflow;

endmodule

`default_nettype wire
